bist_controller: RTL and testbench
==================================

# bist_controller

Built-in self-test sequencer for the 17-bit response path compressed by the 10-bit signature register (modulo-1023 MISR). On `start`, it generates a pseudo-random 17-bit pattern stream for the circuit under test (CUT). It asserts the MISR `valid` strobe aligned to the CUT's response latency, waits for the final signature, and compares it against a golden value. It sits between the test-mode top level and the CUT/MISR pair.

## Interface
- `PATTERN_COUNT`, 256: number of patterns applied per run; legal range 1..65535.
- `CUT_LAT`, 1: CUT pattern-to-response latency in cycles; legal range 0..7.
- `SEED`, 17'h00001: LFSR seed; must be nonzero.
- `GOLDEN`, 10'h000: expected final signature.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: run request; sampled only in IDLE.
- `sig_in` input 10: MISR `Result`.
- `pattern_out` output 17: stimulus to CUT; reset 0.
- `pat_valid` output 1: `pattern_out` is a live pattern; reset 0.
- `misr_valid` output 1: drives MISR `valid`; reset 0.
- `busy` output 1: high in any state other than IDLE; reset 0.
- `done` output 1: one-cycle completion pulse; reset 0.
- `pass` output 1: result of the last completed run; reset 0.

## Operation
- FSM: IDLE -> INIT -> RUN -> DRAIN -> CHECK -> IDLE.
- IDLE: waits for `start`; `start=1` moves the FSM to INIT.
- INIT (1 cycle): LFSR <= `SEED`, pattern counter <= 0, `pass` <= 0.
- RUN (exactly `PATTERN_COUNT` cycles):
  - `pattern_out` = LFSR; `pat_valid` = 1.
  - Each cycle: LFSR <= {lfsr[15:0], lfsr[16]^lfsr[13]} (x^17+x^14+1), counter++.
  - When the counter reaches `PATTERN_COUNT`-1, the FSM moves to DRAIN.
- `misr_valid` = `pat_valid` delayed by `CUT_LAT` cycles through a shift register; with `CUT_LAT=0` it equals `pat_valid`.
- DRAIN (`CUT_LAT`+1 cycles): `pat_valid`=0 and `pattern_out` holds its last value. This lets the last response reach the MISR and its registered result settle.
- CHECK (1 cycle): compares `sig_in` against `GOLDEN`. Next edge: `pass` <= (`sig_in`==`GOLDEN`), `done` <= 1, FSM <= IDLE.
- `pass` holds until the next INIT.
- Counter width: 16 bits. LFSR never reaches all-zero from a nonzero seed.

## Timing
- `start` sampled at edge E0. INIT follows E0; RUN follows E1.
- Patterns are valid after edges E1..E`PATTERN_COUNT`.
- `done`=1 and `pass` are valid for one cycle after edge E(`PATTERN_COUNT`+`CUT_LAT`+3).
- `start` while `busy`: ignored, no queuing.
- `start` in the same cycle as `done`: accepted, because the FSM is already in IDLE.
- `rst_n` low at any time: all outputs and state return to their reset values asynchronously; a run in progress is discarded, with no `done` pulse.
- Outputs are registered except `busy`, which decodes the state register.

## Configuration
- `BIST_ABORT_EN` defined:
  - Adds input port `abort` (1 bit).
  - `abort`=1 in INIT/RUN/DRAIN/CHECK sends the FSM to IDLE at the next edge.
  - On abort: `pat_valid`, `misr_valid` and the shift register are cleared; `pass`=0; no `done` pulse.
  - `abort` in IDLE has no effect. `abort` and `start` together in IDLE: `start` wins.
- `BIST_ABORT_EN` undefined: no `abort` port; runs always complete.

## Test plan
- Reset: hold `rst_n`=0 with clock running -> all outputs 0, FSM in IDLE.
- Nominal run (PATTERN_COUNT=4, CUT_LAT=1, SEED=1):
  - `pattern_out` = 17'h00001, 00002, 00004, 00008 with `pat_valid`=1.
  - `misr_valid` is high for 4 cycles, one cycle later than `pat_valid`.
  - `done` pulses after E8.
- Pass/fail: with a CUT model driving 17'h003FF and GOLDEN=0 (1023 % 1023 = 0) -> `pass`=1. With GOLDEN=10'h001 -> `pass`=0, `done` still pulses.
- Start while busy: pulse `start` again mid-RUN -> ignored; exactly one `done`.
- Back-to-back runs: pulse `start` in the `done` cycle -> new INIT next cycle; `pass` cleared to 0 during INIT.
- Reset mid-run: `rst_n`=0 during DRAIN -> outputs 0 immediately. With `BIST_ABORT_EN`: `abort` in RUN -> IDLE next edge, no `done`, `misr_valid` 0.

Source files
------------

// File: rtl/bist_controller.sv
// BIST sequencer: LFSR pattern source for the CUT, MISR valid alignment and golden-signature check.
// Optional macro BIST_ABORT_EN adds an abort input that cancels a run in progress.
module bist_controller #(
  parameter int unsigned PATTERN_COUNT = 256,
  parameter int unsigned CUT_LAT       = 1,
  parameter logic [16:0] SEED          = 17'h00001,
  parameter logic [9:0]  GOLDEN        = 10'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
`ifdef BIST_ABORT_EN
  input  logic        abort,
`endif
  input  logic [9:0]  sig_in,
  output logic [16:0] pattern_out,
  output logic        pat_valid,
  output logic        misr_valid,
  output logic        busy,
  output logic        done,
  output logic        pass
);

  // state   | meaning
  // S_IDLE  | waiting for start; pass holds last result
  // S_INIT  | load seed, clear pattern counter
  // S_RUN   | one pattern per cycle, PATTERN_COUNT cycles
  // S_DRAIN | CUT_LAT+1 cycles for the last response to reach the MISR
  // S_CHECK | compare sig_in with GOLDEN
  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_DRAIN,
    S_CHECK
  } state_t;

  localparam logic [15:0] RUN_LAST   = 16'(PATTERN_COUNT - 1);
  localparam logic [15:0] DRAIN_LAST = 16'(CUT_LAT);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] cnt;
  logic        abort_hit;
  logic [16:0] lfsr_nxt;

`ifdef BIST_ABORT_EN
  assign abort_hit = abort && (state != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign busy     = (state != S_IDLE);
  assign lfsr_nxt = {pattern_out[15:0], pattern_out[16] ^ pattern_out[13]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_INIT;
      S_INIT:  state_nxt = S_RUN;
      S_RUN:   if (cnt == RUN_LAST) state_nxt = S_DRAIN;
      S_DRAIN: if (cnt == DRAIN_LAST) state_nxt = S_CHECK;
      S_CHECK: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort_hit) state_nxt = S_IDLE;
  end

  // pattern_out doubles as the LFSR register, so it naturally holds through DRAIN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_out <= '0;
      pat_valid   <= 1'b0;
      cnt         <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) pass <= 1'b0;
        end
        S_INIT: begin
          pattern_out <= SEED;
          cnt         <= '0;
          pat_valid   <= 1'b1;
          pass        <= 1'b0;
        end
        S_RUN: begin
          if (cnt == RUN_LAST) begin
            pat_valid <= 1'b0;
            cnt       <= '0;
          end else begin
            pattern_out <= lfsr_nxt;
            cnt         <= cnt + 16'd1;
          end
        end
        S_DRAIN: begin
          cnt <= cnt + 16'd1;
        end
        S_CHECK: begin
          pass <= (sig_in == GOLDEN);
          done <= 1'b1;
        end
        default: ;
      endcase
      if (abort_hit) begin
        pat_valid <= 1'b0;
        pass      <= 1'b0;
        done      <= 1'b0;
      end
    end
  end

  if (CUT_LAT == 0) begin : g_no_dly
    assign misr_valid = pat_valid;
  end else begin : g_dly
    logic [CUT_LAT-1:0] dly_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         dly_q <= '0;
      else if (abort_hit) dly_q <= '0;
      else                dly_q <= CUT_LAT'({dly_q, pat_valid});
    end
    assign misr_valid = dly_q[CUT_LAT-1];
  end

endmodule

// File: tb/tb_bist_controller.sv
// Self-checking bench for bist_controller: directed scenarios plus randomized CUT responses and start timing.
// Exercises the abort port when compiled with BIST_ABORT_EN.
module tb_bist_controller;

  localparam int PC   = 4;
  localparam int L    = 1;
  localparam int GOLD = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
`ifdef BIST_ABORT_EN
  logic        abort;
`endif
  logic [9:0]  sig_in;
  logic [16:0] pattern_out;
  logic        pat_valid;
  logic        misr_valid;
  logic        busy;
  logic        done;
  logic        pass;

  int total = 0;
  int bad   = 0;

  int exp_pat[PC];
  int cut_const;
  int cut_val;
  int pass_exp;
  int resp_q;
  int acc;

  bist_controller #(
    .PATTERN_COUNT(PC),
    .CUT_LAT(L),
    .SEED(17'h00001),
    .GOLDEN(10'(GOLD))
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
`ifdef BIST_ABORT_EN
    .abort(abort),
`endif
    .sig_in(sig_in),
    .pattern_out(pattern_out),
    .pat_valid(pat_valid),
    .misr_valid(misr_valid),
    .busy(busy),
    .done(done),
    .pass(pass)
  );

  always #5 clk = ~clk;

  // CUT with one cycle of latency feeding an additive modulo-1023 signature register
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q <= 0;
      acc    <= 0;
    end else begin
      resp_q <= (cut_const != 0) ? cut_val : (int'(pattern_out) ^ cut_val);
      if (!busy)           acc <= 0;
      else if (misr_valid) acc <= (acc + resp_q) % 1023;
    end
  end
  assign sig_in = 10'(acc);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_sig();
    int s = 0;
    for (int i = 0; i < PC; i++)
      s += (cut_const != 0) ? cut_val : (exp_pat[i] ^ cut_val);
    return s % 1023;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_pass", pass, pass_exp);
      chk("idle_pat_valid", pat_valid, 0);
      chk("idle_misr_valid", misr_valid, 0);
    end
  endtask

  // caller raises start just after a negedge; k counts edges from the one that samples start
  task automatic do_run(input bit mid_start, input bit b2b, input int kill_k, input int abort_k);
    int last;
    int sig;
    last = PC + L + 3;
    sig  = exp_sig();
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0;
`ifdef BIST_ABORT_EN
        abort = 1'b0;
`endif
        pass_exp = 0;
      end
      if (k == kill_k) begin
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_pattern", pattern_out, 0);
        chk("rst_pat_valid", pat_valid, 0);
        chk("rst_misr_valid", misr_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
`ifdef BIST_ABORT_EN
      if (k == abort_k) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_pat_valid", pat_valid, 0);
        chk("abort_misr_valid", misr_valid, 0);
        chk("abort_done", done, 0);
        chk("abort_pass", pass, 0);
        return;
      end
`endif
      chk("busy", busy, (k < last));
      chk("pat_valid", pat_valid, (k >= 1 && k <= PC));
      chk("misr_valid", misr_valid, (k - L >= 1 && k - L <= PC));
      chk("done", done, (k == last));
      if (k >= 1)
        chk("pattern", pattern_out, (k <= PC) ? exp_pat[k-1] : exp_pat[PC-1]);
      if (k == last) begin
        pass_exp = (sig == GOLD) ? 1 : 0;
        chk("pass", pass, pass_exp);
      end else begin
        chk("pass_clear", pass, 0);
      end
      if (mid_start && k == 2) start = 1'b1;
      if (mid_start && k == 3) start = 1'b0;
      if (b2b && k == last)    start = 1'b1;
    end
  endtask

  initial begin
    int x;
    bit ms;
    bit bb;
    x = 1;
    for (int i = 0; i < PC; i++) begin
      exp_pat[i] = x;
      x = ((x << 1) | (((x >> 16) ^ (x >> 13)) & 1)) & 32'h1FFFF;
    end
    cut_const = 0;
    cut_val   = 0;
    pass_exp  = 0;
`ifdef BIST_ABORT_EN
    abort = 1'b0;
`endif

    // reset with clock running and start toggling
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_pattern", pattern_out, 0);
    chk("reset_pat_valid", pat_valid, 0);
    chk("reset_misr_valid", misr_valid, 0);
    chk("reset_done", done, 0);
    chk("reset_pass", pass, 0);
    rst_n = 1'b1;
    start = 1'b0;
    idle(2);

    // nominal: CUT passes patterns through, signature 15 -> fail
    start = 1'b1;
    do_run(0, 0, -1, -1);
    idle(3);

    // constant 0x3FF response: 4*1023 mod 1023 = 0 -> pass, held while idle
    cut_const = 1; cut_val = 32'h3FF;
    start = 1'b1;
    do_run(0, 0, -1, -1);
    idle(3);

    // failing signature with a start pulse mid-run that must be ignored
    cut_const = 1; cut_val = 1;
    start = 1'b1;
    do_run(1, 0, -1, -1);
    idle(4);

    // back-to-back: passing run, then a failing one started in the done cycle
    cut_const = 1; cut_val = 32'h3FF;
    start = 1'b1;
    do_run(0, 1, -1, -1);
    cut_const = 0; cut_val = 32'h155;
    do_run(0, 0, -1, -1);
    idle(2);

    // randomized CUT behaviour and start timing
    for (int r = 0; r < 10; r++) begin
      cut_const = $urandom_range(0, 1);
      if ($urandom_range(0, 2) == 0) begin
        cut_const = 1;
        cut_val = 1023 * $urandom_range(0, 128);
      end else begin
        cut_val = $urandom & 32'h1FFFF;
      end
      ms = 1'($urandom_range(0, 1));
      bb = 1'($urandom_range(0, 1));
      start = 1'b1;
      do_run(ms, bb, -1, -1);
      if (!bb) idle($urandom_range(1, 3));
      else begin
        cut_const = 1; cut_val = 32'h3FF;
        do_run(0, 0, -1, -1);
        idle(1);
      end
    end

    // asynchronous reset during DRAIN discards the run
    cut_const = 1; cut_val = 32'h3FF;
    start = 1'b1;
    do_run(0, 0, PC + 1, -1);
    pass_exp = 0;
    idle(3);

`ifdef BIST_ABORT_EN
    // abort during RUN, then abort together with start in IDLE (start wins)
    start = 1'b1;
    do_run(0, 0, -1, 2);
    pass_exp = 0;
    idle(3);
    start = 1'b1;
    abort = 1'b1;
    do_run(0, 0, -1, -1);
    idle(2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
